// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: default parameter values
// and the receive FSM state encoding.
package ps2_pkg;

  localparam int DATA_BITS_DEF      = 8;
  localparam int PARITY_ODD_DEF     = 1;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into the clk domain through
// equal-depth two-flop synchronizers and flags the falling edge of the
// synchronized PS/2 clock. The data output is aligned with the strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sample,
  output logic data_sync
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // synchronizer chains; the PS/2 clock rests high, so its flops reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b0;
      data_p1 <= 1'b0;
    end else begin
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  // previous synchronized clock high, current low: falling edge
  assign sample    = clk_p2 & ~clk_p1;
  assign data_sync = data_p1;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start bit, DATA_BITS payload bits
// LSB-first, parity bit, stop bit. Reports each frame with a one-cycle
// valid, parity_err or frame_err pulse.
// Optional feature macro PS2_RX_TIMEOUT_EN: aborts a partial frame when
// no PS/2 clock falling edge arrives for TIMEOUT_CYCLES clk cycles.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int PARITY_ODD     = PARITY_ODD_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 sample, data_sync;
  logic                 timeout;
  logic                 parity_ok;
  logic                 cnt_clr, cnt_inc, shift_en, par_ld, dout_ld;
  logic                 valid_nxt, perr_nxt, ferr_nxt;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .sample    (sample),
    .data_sync (data_sync)
  );

  assign busy      = (state != ST_IDLE);
  assign parity_ok = ((^shreg) ^ par_bit) == 1'(PARITY_ODD);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // measures clk cycles since the last PS/2 clock edge while a frame is open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (sample || !busy || timeout)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // a real edge in the same cycle wins over the timeout
  assign timeout = busy && !sample && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_en  = 1'b0;
    par_ld    = 1'b0;
    dout_ld   = 1'b0;
    valid_nxt = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        // a high bit while idle is line noise, not a start bit
        if (sample && !data_sync) begin
          state_nxt = ST_DATA;
          cnt_clr   = 1'b1;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (cnt == CNT_W'(DATA_BITS - 1))
            state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_ld    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_nxt = ST_IDLE;
          if (!data_sync)
            ferr_nxt = 1'b1;
          else if (!parity_ok)
            perr_nxt = 1'b1;
          else begin
            valid_nxt = 1'b1;
            dout_ld   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      state_nxt = ST_IDLE;
      ferr_nxt  = 1'b1;
    end
  end

  // bit counter, shift register, parity latch, result and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc && (cnt != CNT_W'(DATA_BITS)))
        cnt <= cnt + 1'b1;
      if (shift_en)
        shreg <= {data_sync, shreg[DATA_BITS-1:1]};
      if (par_ld)
        par_bit <= data_sync;
      if (dout_ld)
        data_out <= shreg;
      valid      <= valid_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: a table of whole frames applied to an
// odd-parity and an even-parity instance, plus hand-written timeout and
// mid-frame reset sequences.
module tb_ps2_frame_rx;

  localparam int TO   = 300;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] dout0, dout1;
  logic       v0, pe0, fe0, b0;
  logic       v1, pe1, fe1, b1;

  int checks = 0;
  int errors = 0;

  int nv0 = 0, npe0 = 0, nfe0 = 0;
  int nv1 = 0, npe1 = 0, nfe1 = 0;
  int nmulti = 0, nfe_busy = 0;

  always #5 clk = ~clk;

  ps2_frame_rx #(.DATA_BITS(8), .PARITY_ODD(1), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data_out(dout0), .valid(v0), .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );

  ps2_frame_rx #(.DATA_BITS(8), .PARITY_ODD(0), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data_out(dout1), .valid(v1), .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  // pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (v0)  nv0++;
    if (pe0) npe0++;
    if (fe0) nfe0++;
    if (v1)  nv1++;
    if (pe1) npe1++;
    if (fe1) nfe1++;
    if ((int'(v0) + int'(pe0) + int'(fe0)) > 1) nmulti++;
    if ((int'(v1) + int'(pe1) + int'(fe1)) > 1) nmulti++;
    if ((fe0 && b0) || (fe1 && b1)) nfe_busy++;
  end

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         ev0, epe0, efe0;
    logic [7:0] edo0;
    int         ev1, epe1, efe1;
    logic [7:0] edo1;
  } vec_t;

  vec_t tbl[6];
  logic busy_mid;
  int   s_v0, s_pe0, s_fe0, s_v1, s_pe1, s_fe1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic snap();
    s_v0 = nv0; s_pe0 = npe0; s_fe0 = nfe0;
    s_v1 = nv1; s_pe1 = npe1; s_fe1 = nfe1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    @(negedge clk);
    busy_mid = b0;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            data   par   stop  v0 pe0 fe0 do0    v1 pe1 fe1 do1
    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C, 0, 1, 0, 8'h00};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C, 1, 0, 0, 8'h1C};
    tbl[2] = '{8'hF0, 1'b1, 1'b0, 0, 0, 1, 8'h1C, 0, 0, 1, 8'h1C};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 0, 1, 0, 8'h1C, 1, 0, 0, 8'h07};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00, 0, 1, 0, 8'h07};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 0, 1, 0, 8'h00, 1, 0, 0, 8'hFF};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, b0}, 32'd0);
    check("rst_valid", {31'd0, v0}, 32'd0);
    check("rst_perr",  {31'd0, pe0}, 32'd0);
    check("rst_ferr",  {31'd0, fe0}, 32'd0);
    check("rst_dout",  {24'd0, dout0}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // table of whole frames
    for (int k = 0; k < 6; k++) begin
      snap();
      send_frame(tbl[k].d, tbl[k].par, tbl[k].stop);
      check($sformatf("v%0d_busy_mid", k), {31'd0, busy_mid}, 32'd1);
      check($sformatf("v%0d_valid0", k), nv0 - s_v0, tbl[k].ev0);
      check($sformatf("v%0d_perr0", k), npe0 - s_pe0, tbl[k].epe0);
      check($sformatf("v%0d_ferr0", k), nfe0 - s_fe0, tbl[k].efe0);
      check($sformatf("v%0d_dout0", k), {24'd0, dout0}, {24'd0, tbl[k].edo0});
      check($sformatf("v%0d_valid1", k), nv1 - s_v1, tbl[k].ev1);
      check($sformatf("v%0d_perr1", k), npe1 - s_pe1, tbl[k].epe1);
      check($sformatf("v%0d_ferr1", k), nfe1 - s_fe1, tbl[k].efe1);
      check($sformatf("v%0d_dout1", k), {24'd0, dout1}, {24'd0, tbl[k].edo1});
      check($sformatf("v%0d_busy_end", k), {31'd0, b0}, 32'd0);
    end

    // partial frame: start bit plus four data bits, then silence
    snap();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (250) @(posedge clk);
    @(negedge clk);
    check("to_busy_early", {31'd0, b0}, 32'd1);
    check("to_ferr_early", nfe0 - s_fe0, 32'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    check("to_ferr", nfe0 - s_fe0, 32'd1);
    check("to_busy", {31'd0, b0}, 32'd0);
    check("to_valid", nv0 - s_v0, 32'd0);
`else
    check("noto_busy", {31'd0, b0}, 32'd1);
    check("noto_ferr", nfe0 - s_fe0, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
`endif
    snap();
    send_frame(8'h5A, 1'b1, 1'b1);
    check("to_next_valid", nv0 - s_v0, 32'd1);
    check("to_next_dout", {24'd0, dout0}, 32'h5A);
    check("to_next_ferr", nfe0 - s_fe0, 32'd0);

    // reset after the third data bit of 0x29
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mr_busy_in_rst", {31'd0, b0}, 32'd0);
    check("mr_dout_in_rst", {24'd0, dout0}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mr_no_valid", nv0 - s_v0, 32'd0);
    check("mr_no_perr", npe0 - s_pe0, 32'd0);
    check("mr_no_ferr", nfe0 - s_fe0, 32'd0);
    snap();
    send_frame(8'h29, 1'b0, 1'b1);
    check("mr_valid", nv0 - s_v0, 32'd1);
    check("mr_dout", {24'd0, dout0}, 32'h29);
    check("mr_perr", npe0 - s_pe0, 32'd0);

    // global properties over the whole run
    check("onehot_pulses", nmulti, 32'd0);
    check("ferr_with_busy", nfe_busy, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
